// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter in front of an asynchronous SRAM.
// Each granted access runs IDLE -> ACCESS (WAIT_CYCLES+1 cycles) -> DONE; all strobes are registered.
module sram_arbiter #(
  parameter int AW          = 17,
  parameter int DW          = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  input  logic [1:0]    p0_be_n,
  output logic          p0_ack,
  output logic [DW-1:0] p0_rdata,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  input  logic [1:0]    p1_be_n,
  output logic          p1_ack,
  output logic [DW-1:0] p1_rdata,
  output logic          busy,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  output logic          mem_we_n,
  output logic          mem_oe_n,
  output logic [1:0]    mem_be_n,
  input  logic [DW-1:0] mem_dout
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t        state;
  logic          last_grant;  // port granted most recently; also the port owning the current access
  logic          we_q;
  logic [3:0]    cnt;

  logic          pick;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic [1:0]    sel_be_n;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    pick      = p1_req & (~p0_req | ~last_grant);
    sel_we    = p0_we;
    sel_addr  = p0_addr;
    sel_wdata = p0_wdata;
    sel_be_n  = p0_be_n;
    if (pick) begin
      sel_we    = p1_we;
      sel_addr  = p1_addr;
      sel_wdata = p1_wdata;
      sel_be_n  = p1_be_n;
    end
  end

  assign busy = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      we_q       <= 1'b0;
      cnt        <= '0;
      mem_addr   <= '0;
      mem_din    <= '0;
      mem_we_n   <= 1'b1;
      mem_oe_n   <= 1'b1;
      mem_be_n   <= 2'b11;
      p0_ack     <= 1'b0;
      p1_ack     <= 1'b0;
      p0_rdata   <= '0;
      p1_rdata   <= '0;
    end else begin
      p0_ack <= 1'b0;
      p1_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (p0_req || p1_req) begin
            last_grant <= pick;
            we_q       <= sel_we;
            mem_addr   <= sel_addr;
            mem_din    <= sel_wdata;
            mem_be_n   <= sel_be_n;
            mem_we_n   <= ~sel_we;
            mem_oe_n   <= sel_we;
            cnt        <= 4'(WAIT_CYCLES);
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            // Strobes rise entering DONE so address and data are held one cycle past them.
            mem_we_n <= 1'b1;
            mem_oe_n <= 1'b1;
            if (!we_q) begin
              if (last_grant) p1_rdata <= mem_dout;
              else            p0_rdata <= mem_dout;
            end
            p0_ack <= ~last_grant;
            p1_ack <= last_grant;
            state  <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          mem_be_n <= 2'b11;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: one instance with WAIT_CYCLES=1 for directed cases,
// one with WAIT_CYCLES=0 for a random read/write sweep against a reference memory.
module tb_sram_arbiter;

  typedef struct packed {
    logic        port;
    logic        rd;
    logic [15:0] data;
  } exp_t;

  logic clk_sys = 1'b0;
  logic reset_n = 1'b1;
  logic mem_init = 1'b1;
  always #5 clk_sys = ~clk_sys;

  int n_tests = 0;
  int n_fail  = 0;
  exp_t sb_a[$];
  exp_t sb_z[$];

  // Instance A (WAIT_CYCLES=1)
  logic        p0_req_a, p0_we_a, p1_req_a, p1_we_a, p0_ack_a, p1_ack_a, busy_a;
  logic [16:0] p0_addr_a, p1_addr_a, mem_addr_a;
  logic [15:0] p0_wdata_a, p1_wdata_a, p0_rdata_a, p1_rdata_a, mem_din_a, mem_dout_a;
  logic [1:0]  p0_be_n_a, p1_be_n_a, mem_be_n_a;
  logic        mem_we_n_a, mem_oe_n_a;
  logic [15:0] mem_a [0:255];

  // Instance Z (WAIT_CYCLES=0)
  logic        p0_req_z, p0_we_z, p1_req_z, p1_we_z, p0_ack_z, p1_ack_z, busy_z;
  logic [16:0] p0_addr_z, p1_addr_z, mem_addr_z;
  logic [15:0] p0_wdata_z, p1_wdata_z, p0_rdata_z, p1_rdata_z, mem_din_z, mem_dout_z;
  logic [1:0]  p0_be_n_z, p1_be_n_z, mem_be_n_z;
  logic        mem_we_n_z, mem_oe_n_z;
  logic [15:0] mem_z [0:255];
  logic [15:0] ref_z [0:255];

  sram_arbiter #(.AW(17), .DW(16), .WAIT_CYCLES(1)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .p0_req(p0_req_a), .p0_we(p0_we_a), .p0_addr(p0_addr_a), .p0_wdata(p0_wdata_a),
    .p0_be_n(p0_be_n_a), .p0_ack(p0_ack_a), .p0_rdata(p0_rdata_a),
    .p1_req(p1_req_a), .p1_we(p1_we_a), .p1_addr(p1_addr_a), .p1_wdata(p1_wdata_a),
    .p1_be_n(p1_be_n_a), .p1_ack(p1_ack_a), .p1_rdata(p1_rdata_a),
    .busy(busy_a), .mem_addr(mem_addr_a), .mem_din(mem_din_a), .mem_we_n(mem_we_n_a),
    .mem_oe_n(mem_oe_n_a), .mem_be_n(mem_be_n_a), .mem_dout(mem_dout_a)
  );

  sram_arbiter #(.AW(17), .DW(16), .WAIT_CYCLES(0)) dut_z (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .p0_req(p0_req_z), .p0_we(p0_we_z), .p0_addr(p0_addr_z), .p0_wdata(p0_wdata_z),
    .p0_be_n(p0_be_n_z), .p0_ack(p0_ack_z), .p0_rdata(p0_rdata_z),
    .p1_req(p1_req_z), .p1_we(p1_we_z), .p1_addr(p1_addr_z), .p1_wdata(p1_wdata_z),
    .p1_be_n(p1_be_n_z), .p1_ack(p1_ack_z), .p1_rdata(p1_rdata_z),
    .busy(busy_z), .mem_addr(mem_addr_z), .mem_din(mem_din_z), .mem_we_n(mem_we_n_z),
    .mem_oe_n(mem_oe_n_z), .mem_be_n(mem_be_n_z), .mem_dout(mem_dout_z)
  );

  // SRAM models: 256 words indexed by the low address byte, byte-masked writes.
  assign mem_dout_a = mem_a[mem_addr_a[7:0]];
  assign mem_dout_z = mem_z[mem_addr_z[7:0]];

  always @(posedge clk_sys) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) begin
        mem_a[i] <= 16'h0000;
        mem_z[i] <= 16'h0000;
      end
      mem_a[8'h23] <= 16'hBEEF;
      mem_a[8'h10] <= 16'h1111;
      mem_a[8'h20] <= 16'h2222;
    end else begin
      if (!mem_we_n_a) begin
        if (!mem_be_n_a[0]) mem_a[mem_addr_a[7:0]][7:0]  <= mem_din_a[7:0];
        if (!mem_be_n_a[1]) mem_a[mem_addr_a[7:0]][15:8] <= mem_din_a[15:8];
      end
      if (!mem_we_n_z) begin
        if (!mem_be_n_z[0]) mem_z[mem_addr_z[7:0]][7:0]  <= mem_din_z[7:0];
        if (!mem_be_n_z[1]) mem_z[mem_addr_z[7:0]][15:8] <= mem_din_z[15:8];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard whenever either instance acks.
  always @(negedge clk_sys) begin
    exp_t e;
    if (reset_n && !mem_init) begin
      check("strobe_excl_a", 32'(mem_we_n_a | mem_oe_n_a), 32'd1);
      check("strobe_excl_z", 32'(mem_we_n_z | mem_oe_n_z), 32'd1);
      if (p0_ack_a || p1_ack_a) begin
        check("single_ack_a", 32'(p0_ack_a & p1_ack_a), 32'd0);
        if (sb_a.size() == 0) check("unexpected_ack_a", 32'd1, 32'd0);
        else begin
          e = sb_a.pop_front();
          check("ack_port_a", 32'(p1_ack_a), 32'(e.port));
          if (e.rd) check("rdata_a", 32'(e.port ? p1_rdata_a : p0_rdata_a), 32'(e.data));
        end
      end
      if (p0_ack_z || p1_ack_z) begin
        check("single_ack_z", 32'(p0_ack_z & p1_ack_z), 32'd0);
        if (sb_z.size() == 0) check("unexpected_ack_z", 32'd1, 32'd0);
        else begin
          e = sb_z.pop_front();
          check("ack_port_z", 32'(p1_ack_z), 32'(e.port));
          if (e.rd) check("rdata_z", 32'(e.port ? p1_rdata_z : p0_rdata_z), 32'(e.data));
        end
      end
    end
  end

  task automatic drive_a(input logic port, input logic we, input logic [16:0] addr,
                         input logic [15:0] data, input logic [1:0] be_n);
    if (port) begin
      p1_we_a = we; p1_addr_a = addr; p1_wdata_a = data; p1_be_n_a = be_n; p1_req_a = 1'b1;
    end else begin
      p0_we_a = we; p0_addr_a = addr; p0_wdata_a = data; p0_be_n_a = be_n; p0_req_a = 1'b1;
    end
  endtask

  task automatic drive_z(input logic port, input logic we, input logic [16:0] addr,
                         input logic [15:0] data, input logic [1:0] be_n);
    if (port) begin
      p1_we_z = we; p1_addr_z = addr; p1_wdata_z = data; p1_be_n_z = be_n; p1_req_z = 1'b1;
    end else begin
      p0_we_z = we; p0_addr_z = addr; p0_wdata_z = data; p0_be_n_z = be_n; p0_req_z = 1'b1;
    end
  endtask

  // One request on instance A; expects ack in cycle WAIT_CYCLES+2 = 3.
  task automatic op_a(input logic port, input logic we, input logic [16:0] addr,
                      input logic [15:0] data, input logic [1:0] be_n, input logic [15:0] rd_exp);
    bit found = 0;
    int lat = 0;
    @(posedge clk_sys); #1;
    sb_a.push_back('{port: port, rd: ~we, data: rd_exp});
    drive_a(port, we, addr, data, be_n);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_sys);
      if ((port ? p1_ack_a : p0_ack_a) == 1'b1) begin lat = k; found = 1; break; end
    end
    check("op_a_timeout", 32'(found), 32'd1);
    if (found) check("op_a_latency", 32'(lat), 32'd3);
    p0_req_a = 1'b0; p1_req_a = 1'b0;
  endtask

  task automatic op_z(input logic port, input logic we, input logic [16:0] addr,
                      input logic [15:0] data, input logic [1:0] be_n, input logic [15:0] rd_exp);
    bit found = 0;
    int lat = 0;
    @(posedge clk_sys); #1;
    sb_z.push_back('{port: port, rd: ~we, data: rd_exp});
    drive_z(port, we, addr, data, be_n);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_sys);
      if ((port ? p1_ack_z : p0_ack_z) == 1'b1) begin lat = k; found = 1; break; end
    end
    check("op_z_timeout", 32'(found), 32'd1);
    if (found) check("op_z_latency", 32'(lat), 32'd2);
    p0_req_z = 1'b0; p1_req_z = 1'b0;
  endtask

  // Both ports hold requests; grants must alternate starting at 'first', acks 4 cycles apart.
  task automatic contend_a(input int n, input logic first);
    int acks = 0;
    int last_cyc = 0;
    logic p = first;
    for (int i = 0; i < n; i++) begin
      sb_a.push_back('{port: p, rd: 1'b1, data: p ? 16'h2222 : 16'h1111});
      p = ~p;
    end
    @(posedge clk_sys); #1;
    drive_a(1'b0, 1'b0, 17'h00010, 16'h0000, 2'b00);
    drive_a(1'b1, 1'b0, 17'h00020, 16'h0000, 2'b00);
    for (int c = 0; c < 60 && acks < n; c++) begin
      @(negedge clk_sys);
      if (p0_ack_a || p1_ack_a) begin
        if (acks > 0) check("contend_spacing", 32'(c - last_cyc), 32'd4);
        last_cyc = c;
        acks++;
        if (acks == n) begin p0_req_a = 1'b0; p1_req_a = 1'b0; end
      end
    end
    check("contend_ack_count", 32'(acks), 32'(n));
    p0_req_a = 1'b0; p1_req_a = 1'b0;
  endtask

  initial begin
    logic        port, we;
    logic [16:0] addr;
    logic [15:0] data;
    logic [1:0]  be_n;

    {p0_req_a, p0_we_a, p1_req_a, p1_we_a} = '0;
    {p0_addr_a, p1_addr_a, p0_wdata_a, p1_wdata_a} = '0;
    {p0_be_n_a, p1_be_n_a} = 4'hF;
    {p0_req_z, p0_we_z, p1_req_z, p1_we_z} = '0;
    {p0_addr_z, p1_addr_z, p0_wdata_z, p1_wdata_z} = '0;
    {p0_be_n_z, p1_be_n_z} = 4'hF;
    for (int i = 0; i < 256; i++) ref_z[i] = 16'h0000;

    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_we_n", 32'(mem_we_n_a), 32'd1);
    check("rst_oe_n", 32'(mem_oe_n_a), 32'd1);
    check("rst_be_n", 32'(mem_be_n_a), 32'd3);
    check("rst_addr", 32'(mem_addr_a), 32'd0);
    check("rst_din", 32'(mem_din_a), 32'd0);
    check("rst_acks", 32'({p0_ack_a, p1_ack_a}), 32'd0);
    check("rst_rdata", 32'({p0_rdata_a, p1_rdata_a}), 32'd0);
    reset_n  = 1'b1;
    mem_init = 1'b0;

    // Single read by p0 from 0x00123, cycle by cycle.
    @(posedge clk_sys); #1;
    sb_a.push_back('{port: 1'b0, rd: 1'b1, data: 16'hBEEF});
    drive_a(1'b0, 1'b0, 17'h00123, 16'h0000, 2'b00);
    @(negedge clk_sys);
    check("rd_c0_busy", 32'(busy_a), 32'd0);
    @(negedge clk_sys);
    check("rd_c1_oe_n", 32'(mem_oe_n_a), 32'd0);
    check("rd_c1_we_n", 32'(mem_we_n_a), 32'd1);
    check("rd_c1_addr", 32'(mem_addr_a), 32'h00123);
    check("rd_c1_busy", 32'(busy_a), 32'd1);
    @(negedge clk_sys);
    check("rd_c2_oe_n", 32'(mem_oe_n_a), 32'd0);
    check("rd_c2_ack", 32'(p0_ack_a), 32'd0);
    @(negedge clk_sys);
    check("rd_c3_oe_n", 32'(mem_oe_n_a), 32'd1);
    check("rd_c3_we_n", 32'(mem_we_n_a), 32'd1);
    check("rd_c3_ack", 32'(p0_ack_a), 32'd1);
    check("rd_c3_rdata", 32'(p0_rdata_a), 32'hBEEF);
    check("rd_c3_p1_rdata", 32'(p1_rdata_a), 32'd0);
    p0_req_a = 1'b0;
    @(negedge clk_sys);
    check("rd_c4_busy", 32'(busy_a), 32'd0);
    check("rd_c4_be_n", 32'(mem_be_n_a), 32'd3);

    // Single write by p1 of 0xA5A5 to 0x1FFFF with upper lane only.
    @(posedge clk_sys); #1;
    sb_a.push_back('{port: 1'b1, rd: 1'b0, data: 16'h0000});
    drive_a(1'b1, 1'b1, 17'h1FFFF, 16'hA5A5, 2'b01);
    @(negedge clk_sys);
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk_sys);
      check("wr_we_n", 32'(mem_we_n_a), 32'd0);
      check("wr_oe_n", 32'(mem_oe_n_a), 32'd1);
      check("wr_be_n", 32'(mem_be_n_a), 32'd1);
      check("wr_din", 32'(mem_din_a), 32'hA5A5);
      check("wr_addr", 32'(mem_addr_a), 32'h1FFFF);
    end
    @(negedge clk_sys);
    check("wr_c3_we_n", 32'(mem_we_n_a), 32'd1);
    check("wr_c3_ack", 32'(p1_ack_a), 32'd1);
    check("wr_c3_addr", 32'(mem_addr_a), 32'h1FFFF);
    check("wr_c3_din", 32'(mem_din_a), 32'hA5A5);
    check("wr_c3_p1_rdata", 32'(p1_rdata_a), 32'd0);
    check("wr_c3_p0_rdata", 32'(p0_rdata_a), 32'hBEEF);
    p1_req_a = 1'b0;

    // Read back: only the upper byte was written.
    op_a(1'b0, 1'b0, 17'h1FFFF, 16'h0000, 2'b00, 16'hA500);

    // p0 was granted last, so the tie goes to p1 first.
    contend_a(2, 1'b1);

    // Reset during the ACCESS phase of a write.
    @(posedge clk_sys); #1;
    drive_a(1'b0, 1'b1, 17'h00030, 16'h7777, 2'b00);
    @(negedge clk_sys);
    @(negedge clk_sys);
    check("abort_we_n_before", 32'(mem_we_n_a), 32'd0);
    #1 reset_n = 1'b0;
    #1;
    check("abort_we_n", 32'(mem_we_n_a), 32'd1);
    check("abort_busy", 32'(busy_a), 32'd0);
    check("abort_be_n", 32'(mem_be_n_a), 32'd3);
    p0_req_a = 1'b0;
    repeat (2) @(posedge clk_sys);
    @(negedge clk_sys);
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_sys);
      check("post_abort_busy", 32'(busy_a), 32'd0);
      check("post_abort_ack", 32'({p0_ack_a, p1_ack_a}), 32'd0);
    end
    check("post_abort_rdata", 32'(p0_rdata_a), 32'd0);

    // After reset p0 wins the first tie.
    contend_a(4, 1'b0);

    // WAIT_CYCLES=0 sweep against the reference memory.
    for (int i = 0; i < 256; i++) begin
      port = 1'($urandom_range(0, 1));
      we   = 1'($urandom_range(0, 1));
      addr = 17'($urandom_range(0, 15));
      data = 16'($urandom);
      be_n = 2'($urandom_range(0, 3));
      if (we) begin
        if (!be_n[0]) ref_z[addr[7:0]][7:0]  = data[7:0];
        if (!be_n[1]) ref_z[addr[7:0]][15:8] = data[15:8];
        op_z(port, 1'b1, addr, data, be_n, 16'h0000);
      end else begin
        op_z(port, 1'b0, addr, data, be_n, ref_z[addr[7:0]]);
      end
    end

    repeat (4) @(negedge clk_sys);
    check("sb_a_drained", 32'(sb_a.size()), 32'd0);
    check("sb_z_drained", 32'(sb_z.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
